adc_decim_acq: RTL and testbench

Parametrised successor to the single-mode ADC capture/decimator. It muxes the two ADC output lanes by DCO phase and groups samples into windows of N = decimation+1 samples. Per window it emits one result in one of three modes: sample, peak (min/max) or boxcar average. It sits between the ADC pins and the capture buffer/trigger logic, and decim_clk serves as the write strobe.

---
 rtl/adc_decim_acq.sv | 160 ++++++++++++++++
 tb/tb_adc_decim_acq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_decim_acq.sv
// Two-lane ADC capture with windowed decimation: one result per window of
// decimation+1 samples, as last sample, min/max peak pair, or shifted boxcar sum.
module adc_decim_acq #(
    parameter int DATA_W  = 8,
    parameter int DECIM_W = 16,
    parameter int SHIFT_W = 5,
    parameter int ACC_W   = DATA_W + DECIM_W
) (
    input  logic               adc_clk,
    input  logic               rst,
    input  logic               adc_dco,
    input  logic [DATA_W-1:0]  adc_da,
    input  logic [DATA_W-1:0]  adc_db,
    input  logic               enable,
    input  logic [DECIM_W-1:0] decimation,
    input  logic [1:0]         mode,
    input  logic [SHIFT_W-1:0] avg_shift,
    output logic [DATA_W-1:0]  adc_data,
    output logic [DATA_W-1:0]  adc_max,
    output logic               decim_clk,
    output logic               busy
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic [DATA_W-1:0]    s_reg, s_next;
    logic [DECIM_W-1:0]   cnt_reg, cnt_next;
    logic [DECIM_W-1:0]   dec_reg, dec_next;
    logic [1:0]           mode_reg, mode_next;
    logic [SHIFT_W-1:0]   shift_reg, shift_next;
    logic [ACC_W-1:0]     sum_reg, sum_next;
    logic [DATA_W-1:0]    min_reg, min_next;
    logic [DATA_W-1:0]    max_reg, max_next;
    logic [DATA_W-1:0]    data_reg, data_next;
    logic [DATA_W-1:0]    peak_reg, peak_next;
    logic                 strobe_reg, strobe_next;

    // Window statistics including the sample being consumed this cycle
    logic [ACC_W-1:0]     sum_acc;
    logic [DATA_W-1:0]    min_acc;
    logic [DATA_W-1:0]    max_acc;
    logic [ACC_W-1:0]     avg_full;
    logic [DATA_W-1:0]    avg_sat;
    logic                 first;

    always_comb begin
        first    = (cnt_reg == '0);
        sum_acc  = sum_reg + {{(ACC_W-DATA_W){1'b0}}, s_reg};
        min_acc  = (first || (s_reg < min_reg)) ? s_reg : min_reg;
        max_acc  = (first || (s_reg > max_reg)) ? s_reg : max_reg;
        avg_full = sum_acc >> shift_reg;
        avg_sat  = (|avg_full[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : avg_full[DATA_W-1:0];
    end

    always_comb begin
        s_next      = adc_dco ? adc_da : adc_db;
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        dec_next    = dec_reg;
        mode_next   = mode_reg;
        shift_next  = shift_reg;
        sum_next    = sum_reg;
        min_next    = min_reg;
        max_next    = max_reg;
        data_next   = data_reg;
        peak_next   = peak_reg;
        strobe_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    dec_next   = decimation;
                    mode_next  = mode;
                    shift_next = avg_shift;
                    cnt_next   = '0;
                    sum_next   = '0;
                    min_next   = '0;
                    max_next   = '0;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    sum_next   = '0;
                    min_next   = '0;
                    max_next   = '0;
                end else if (cnt_reg == dec_reg) begin
                    strobe_next = 1'b1;
                    case (mode_reg)
                        2'd1: begin
                            data_next = min_acc;
                            peak_next = max_acc;
                        end
                        2'd2: begin
                            data_next = avg_sat;
                            peak_next = max_acc;
                        end
                        default: begin
                            data_next = s_reg;
                            peak_next = s_reg;
                        end
                    endcase
                    cnt_next   = '0;
                    sum_next   = '0;
                    min_next   = '0;
                    max_next   = '0;
                    // New config only takes effect at a window boundary
                    dec_next   = decimation;
                    mode_next  = mode;
                    shift_next = avg_shift;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    sum_next = sum_acc;
                    min_next = min_acc;
                    max_next = max_acc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            s_reg      <= '0;
            cnt_reg    <= '0;
            dec_reg    <= '0;
            mode_reg   <= '0;
            shift_reg  <= '0;
            sum_reg    <= '0;
            min_reg    <= '0;
            max_reg    <= '0;
            data_reg   <= '0;
            peak_reg   <= '0;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            s_reg      <= s_next;
            cnt_reg    <= cnt_next;
            dec_reg    <= dec_next;
            mode_reg   <= mode_next;
            shift_reg  <= shift_next;
            sum_reg    <= sum_next;
            min_reg    <= min_next;
            max_reg    <= max_next;
            data_reg   <= data_next;
            peak_reg   <= peak_next;
            strobe_reg <= strobe_next;
        end
    end

    assign adc_data  = data_reg;
    assign adc_max   = peak_reg;
    assign decim_clk = strobe_reg;
    assign busy      = (state_reg == ACTIVE);

endmodule

// File: tb/tb_adc_decim_acq.sv
// Randomized bench for adc_decim_acq: a window-level reference model queues
// expected results; a negedge monitor compares every strobe against the queue.
module tb_adc_decim_acq;

    logic        adc_clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_dco = 1'b0;
    logic [7:0]  adc_da = '0;
    logic [7:0]  adc_db = '0;
    logic        enable = 1'b0;
    logic [15:0] decimation = '0;
    logic [1:0]  mode = '0;
    logic [4:0]  avg_shift = '0;
    logic [7:0]  adc_data;
    logic [7:0]  adc_max;
    logic        decim_clk;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    adc_decim_acq dut (
        .adc_clk    (adc_clk),
        .rst        (rst),
        .adc_dco    (adc_dco),
        .adc_da     (adc_da),
        .adc_db     (adc_db),
        .enable     (enable),
        .decimation (decimation),
        .mode       (mode),
        .avg_shift  (avg_shift),
        .adc_data   (adc_data),
        .adc_max    (adc_max),
        .decim_clk  (decim_clk),
        .busy       (busy)
    );

    always #5 adc_clk = ~adc_clk;

    typedef struct {
        int unsigned d;
        int unsigned x;
    } res_t;

    // Reference model state: a window is simply the list of samples it holds
    res_t          exp_q[$];
    int unsigned   win[$];
    int unsigned   m_prev = 0;
    bit            m_active = 0;
    bit            m_strobe = 0;
    int unsigned   m_dec = 0;
    int unsigned   m_mode = 0;
    int unsigned   m_shift = 0;

    function automatic res_t reference(input int unsigned s[$], input int unsigned md,
                                       input int unsigned sh);
        res_t r;
        int unsigned sum = 0;
        int unsigned mn = 255;
        int unsigned mx = 0;
        foreach (s[i]) begin
            sum += s[i];
            if (s[i] < mn) mn = s[i];
            if (s[i] > mx) mx = s[i];
        end
        if (md == 1) begin
            r.d = mn;
            r.x = mx;
        end else if (md == 2) begin
            r.d = ((sum >> sh) > 255) ? 255 : (sum >> sh);
            r.x = mx;
        end else begin
            r.d = s[s.size()-1];
            r.x = s[s.size()-1];
        end
        return r;
    endfunction

    always @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            m_prev = 0;
            m_active = 0;
            m_strobe = 0;
            win.delete();
            exp_q.delete();
        end else begin
            m_strobe = 0;
            if (!m_active) begin
                if (enable) begin
                    m_dec = decimation; m_mode = mode; m_shift = avg_shift;
                    win.delete();
                    m_active = 1;
                end
            end else if (!enable) begin
                m_active = 0;
                win.delete();
            end else begin
                win.push_back(m_prev);
                if (win.size() == m_dec + 1) begin
                    exp_q.push_back(reference(win, m_mode, m_shift));
                    m_strobe = 1;
                    win.delete();
                    m_dec = decimation; m_mode = mode; m_shift = avg_shift;
                end
            end
            m_prev = adc_dco ? adc_da : adc_db;
        end
    end

    always @(negedge adc_clk) begin
        if (!rst) begin
            res_t e;
            checks++;
            if (busy !== m_active) begin
                errors++;
                $display("FAIL busy: got %0b expected %0b at %0t", busy, m_active, $time);
            end
            checks++;
            if (decim_clk !== m_strobe) begin
                errors++;
                $display("FAIL strobe: got %0b expected %0b at %0t", decim_clk, m_strobe, $time);
            end
            if (decim_clk === 1'b1) begin
                strobes++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected strobe data=%0d max=%0d at %0t",
                             adc_data, adc_max, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (adc_data !== e.d[7:0] || adc_max !== e.x[7:0]) begin
                        errors++;
                        $display("FAIL result: got data=%0d max=%0d expected data=%0d max=%0d at %0t",
                                 adc_data, adc_max, e.d, e.x, $time);
                    end else begin
                        $display("txn %0d: data=%0d max=%0d", strobes, adc_data, adc_max);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        checks++;
        if (adc_data !== 8'd0 || adc_max !== 8'd0 || decim_clk !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got data=%0d max=%0d strobe=%0b busy=%0b expected all zero",
                     tag, adc_data, adc_max, decim_clk, busy);
        end
    endtask

    // One call = one stimulus phase; inputs change only on negedges
    task automatic run(input int cycles, input int md, input int dec, input int sh,
                       input int lo, input int drop_pct, input int chg_pct);
        @(negedge adc_clk);
        mode = md[1:0];
        decimation = dec[15:0];
        avg_shift = sh[4:0];
        for (int i = 0; i < cycles; i++) begin
            adc_da  = 8'($urandom_range(lo, 255));
            adc_db  = 8'($urandom_range(lo, 255));
            adc_dco = 1'($urandom_range(0, 1));
            enable  = ($urandom_range(0, 99) >= drop_pct);
            if ($urandom_range(0, 99) < chg_pct) begin
                decimation = 16'($urandom_range(0, 5));
                mode       = 2'($urandom_range(0, 3));
                avg_shift  = 5'($urandom_range(0, 4));
            end
            @(negedge adc_clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge adc_clk);
        check_zero("reset");
        rst = 1'b0;

        run(40, 0, 3, 0, 0, 0, 0);     // sample mode
        run(40, 2, 3, 2, 0, 0, 0);     // average, true mean of 4
        run(40, 2, 3, 0, 200, 0, 0);   // average saturating
        run(50, 1, 4, 0, 0, 0, 0);     // peak
        run(20, 0, 0, 0, 0, 0, 0);     // strobe every cycle
        run(20, 2, 0, 3, 0, 0, 0);     // single-sample average
        run(30, 3, 2, 0, 0, 0, 0);     // reserved mode behaves as sample
        run(300, 1, 2, 1, 0, 8, 10);   // random config changes and enable drops

        // Asynchronous reset in the middle of activity
        @(posedge adc_clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge adc_clk);
        check_zero("reset_hold");
        rst = 1'b0;

        run(300, 2, 1, 1, 0, 5, 10);
        enable = 1'b0;
        repeat (3) @(negedge adc_clk);

        checks++;
        if (strobes < 50) begin
            errors++;
            $display("FAIL strobe_count: got %0d expected at least 50", strobes);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending results expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
